// File: rtl/nn_frame_sequencer.sv
// nn_frame_sequencer: collects a sample frame for the network, waits for it to settle, then picks the winning class by signed argmax.
module nn_frame_sequencer #(
  parameter int N_IN   = 80,
  parameter int IN_W   = 6,
  parameter int N_OUT  = 10,
  parameter int OUT_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_last,
  output logic [N_IN*IN_W-1:0]   nn_in,
  input  logic [N_OUT*OUT_W-1:0] nn_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_class,
  output logic [OUT_W-1:0]       out_score,
  output logic                   frame_err,
  output logic                   busy
);
  typedef enum logic [2:0] {S_LOAD, S_DRAIN, S_SETTLE, S_CAPTURE, S_ARGMAX, S_DONE} state_e;
  state_e                   state_q, state_d;
  logic [6:0]               cnt_q, cnt_d;
  logic [3:0]               settle_q, settle_d;
  logic [3:0]               idx_q, idx_d;
  logic [3:0]               best_idx_q, best_idx_d;
  logic signed [OUT_W-1:0]  best_q, best_d;
  logic                     out_valid_q, out_valid_d;
  logic [3:0]               out_class_q, out_class_d;
  logic [OUT_W-1:0]         out_score_q, out_score_d;
  logic                     frame_err_q, frame_err_d;
  logic [IN_W-1:0]          nn_q [N_IN];
  logic signed [OUT_W-1:0]  score_q [N_OUT];
  logic signed [OUT_W-1:0]  score_w [N_OUT];
  logic                     acc, upd;
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign nn_in[i*IN_W +: IN_W] = nn_q[i];
  end
  for (genvar i = 0; i < N_OUT; i++) begin : g_out
    assign score_w[i] = nn_out[i*OUT_W +: OUT_W];
  end
  assign in_ready  = state_q == S_LOAD || state_q == S_DRAIN;
  assign busy      = !in_ready;
  assign acc       = in_valid && in_ready;
  assign upd       = score_q[idx_q] > best_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_score = out_score_q;
  assign frame_err = frame_err_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
    frame_err_d = 1'b0;
    case (state_q)
      S_LOAD: if (acc) begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'(N_IN-1)) begin
          cnt_d       = '0;
          frame_err_d = !in_last;
          state_d     = in_last ? S_SETTLE : S_DRAIN;
          settle_d    = 4'(SETTLE-1);
        end else if (in_last) begin
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end
      end
      S_DRAIN: state_d = (acc && in_last) ? S_LOAD : S_DRAIN;
      S_SETTLE: begin
        settle_d = settle_q - 4'd1;
        state_d  = settle_q == '0 ? S_CAPTURE : S_SETTLE;
      end
      S_CAPTURE: begin
        best_d     = score_w[0];
        best_idx_d = '0;
        idx_d      = 4'd1;
        state_d    = S_ARGMAX;
      end
      S_ARGMAX: begin
        best_d     = upd ? score_q[idx_q] : best_q;
        best_idx_d = upd ? idx_q : best_idx_q;
        idx_d      = idx_q + 4'd1;
        if (idx_q == 4'(N_OUT-1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_class_d = best_idx_d;
          out_score_d = best_d;
        end
      end
      S_DONE: if (out_ready) begin
        state_d     = S_LOAD;
        out_valid_d = 1'b0;
      end
      default: state_d = S_LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      settle_q    <= '0;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_q      <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      idx_q       <= idx_d;
      best_idx_q  <= best_idx_d;
      best_q      <= best_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
      frame_err_q <= frame_err_d;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) nn_q <= '{default: '0};
    else if (acc && state_q == S_LOAD) nn_q[cnt_q] <= in_data;
  // nn_out is only trusted at the capture edge, after the settle window.
  always_ff @(posedge clk)
    if (state_q == S_CAPTURE) score_q <= score_w;
endmodule

// File: doc/nn_frame_sequencer.md
# nn_frame_sequencer

Serial-to-parallel frame sequencer and result arbiter for the 80-input, 10-output combinational PLL classifier network. It collects one 80-sample frame of 6-bit inputs from a valid/ready stream and drives them onto the network's parallel input bus. It then waits a fixed settle time, captures the ten 8-bit network outputs, and resolves the winning class with a sequential signed argmax. The result goes out on a valid/ready handshake, so the purely combinational network can sit behind a clocked interface.

## Interface
- N_IN, 80: samples per frame (network inputs)
- IN_W, 6: sample width, unsigned
- N_OUT, 10: network outputs (classes)
- OUT_W, 8: network output width, two's-complement signed
- SETTLE, 2: cycles allowed for network settling; legal range 1..15
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  sample valid
- in_ready  output  1  sample accepted when in_valid && in_ready
- in_data  input  IN_W  sample value
- in_last  input  1  marks the final sample of a frame
- nn_in  output  N_IN*IN_W  network input bus; sample k (0-based) occupies bits [k*IN_W +: IN_W]
- nn_out  input  N_OUT*OUT_W  network output bus; class j occupies bits [j*OUT_W +: OUT_W]
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_class  output  4  winning class index, 0..N_OUT-1
- out_score  output  OUT_W  winning signed score
- frame_err  output  1  one-cycle pulse on a frame-length error
- busy  output  1  high in SETTLE, CAPTURE, ARGMAX, DONE

## Operation
- States: LOAD, DRAIN, SETTLE, CAPTURE, ARGMAX, DONE. Reset enters LOAD.
- in_ready = (state==LOAD || state==DRAIN), decoded from state.

**LOAD**
- An accepted sample is written to nn_in slot cnt, then cnt increments. cnt is 7 bits and resets to 0.
- Accept with cnt==N_IN-1 and in_last=1: go to SETTLE, cnt←0.
- Accept with in_last=1 and cnt<N_IN-1 (short frame): frame_err pulse, cnt←0, stay in LOAD. nn_in is not cleared.
- Accept with cnt==N_IN-1 and in_last=0 (long frame): frame_err pulse, cnt←0, go to DRAIN.

**DRAIN**
- Accept and discard samples. An accept with in_last=1 returns to LOAD.

**SETTLE**
- nn_in is frozen. A down-counter loaded with SETTLE-1 counts down; at 0, go to CAPTURE.

**CAPTURE**
- Latch all of nn_out into an internal score register.
- best←score[0], best_idx←0, idx←1. Go to ARGMAX.

**ARGMAX**
- One signed compare per cycle: if score[idx] > best (strict), update best and best_idx.
- Ties keep the lower index.
- After the compare at idx==N_OUT-1, go to DONE.

**DONE**
- out_valid=1; out_class=best_idx and out_score=best, held stable.
- On out_ready, go to LOAD with out_valid←0 in the same edge.
- No new samples are accepted until the handshake completes.

**Outputs and reset**
- out_class and out_score are registered and hold their last value outside DONE.
- Reset values: out_valid=0, out_class=0, out_score=0, frame_err=0, nn_in all 0, busy=0, cnt=0, in_ready=1 (state LOAD).
- Reset asserted in any state aborts immediately; no partial result is emitted.

## Timing
- Throughput: one sample per cycle while in_ready=1.
- Latency: the edge accepting the final sample is E0. out_valid rises after edge E(SETTLE+N_OUT), i.e. 12 cycles with the defaults.
- Breakdown: SETTLE cycles in SETTLE, 1 in CAPTURE, N_OUT-1 in ARGMAX.
- nn_out is sampled only at the CAPTURE edge. The network must settle within SETTLE cycles plus one from the last nn_in change.
- frame_err is registered: high for exactly one cycle after the offending accept edge.
- in_ready is 0 from E0 until the cycle after the out_ready handshake.
- out_valid is held indefinitely under back-pressure; outputs must not change while out_valid=1 && out_ready=0.

## Test plan
- **Normal frame:** 80 samples with data=k%64 and in_last on #80; nn_out scores {-5,3,7,-128,7,0,1,2,6,-1}.
  - nn_in slot k = k%64.
  - out_valid rises 12 cycles after the last accept.
  - out_class=2, out_score=7 (tie with class 4 resolves low).
- **All-negative scores:** scores {-3,-2,-128,...,-128}.
  - out_class=1, out_score=-2. Confirms signed compare and that class 0 is not selected by default.
- **Short frame:** in_last on sample #40.
  - frame_err pulses once; in_ready stays 1.
  - A following correct 80-sample frame produces a normal result.
- **Long frame:** 80 samples without in_last, then 5 more with in_last on the 5th.
  - frame_err pulses once at sample #80; the extra samples are discarded in DRAIN.
  - Next frame: busy=0 and cnt=0 at its start.
- **Back-pressure and gaps:** in_valid toggled 1/0 during load; out_ready held 0 for 6 cycles after out_valid.
  - Result is unchanged and stable throughout; in_ready=0 until the handshake, then 1 the next cycle.
- **Reset mid-ARGMAX:** rst_n low for 1 cycle at the 4th ARGMAX cycle.
  - Immediately: out_valid=0, nn_in=0, in_ready=1.
  - No result is emitted for the aborted frame.
